// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM states, default timeout.
package mem_ctrl_pkg;

    localparam int TIMEOUT_DEFAULT = 16;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Little-endian lane handling: byte enables, store replication, load extraction/extension.
module mem_align
    import mem_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [31:0] byte_shift;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_shift = rdata >> {addr_lo, 3'b000};
    assign byte_lane  = byte_shift[7:0];
    assign half_lane  = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Decode access size from the op and format lanes accordingly.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        be         = 4'b0000;
        wdata_lane = wdata;
        rdata_ext  = rdata;
        misaligned = 1'b0;
        case (op)
            OP_LB, OP_LBU, OP_SB: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = (op == OP_LB) ? {{24{byte_lane[7]}}, byte_lane}
                                           : {24'h000000, byte_lane};
            end
            OP_LH, OP_LHU, OP_SH: begin
                misaligned = addr_lo[0];
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = (op == OP_LH) ? {{16{half_lane[15]}}, half_lane}
                                           : {16'h0000, half_lane};
            end
            OP_LW, OP_SW: begin
                misaligned = |addr_lo;
                be         = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// MEM stage controller: launches one bus access per memory op, stalls upstream
// until it completes, and returns formatted load data to writeback.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        write_reg_en_i,
    input  logic [4:0]  write_reg_addr_i,
    input  logic [31:0] write_reg_data_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stall_o,
    output logic        write_reg_en_o,
    output logic [4:0]  write_reg_addr_o,
    output logic [31:0] write_reg_data_o,
    output logic        mem_err_o
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [31:0] addr_q, wdata_q, data_q;
    logic [3:0]  op_q, be_q;
    logic [4:0]  rd_q;

    logic [3:0]  align_op;
    logic [1:0]  align_addr;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_rdata;
    logic        al_mis;
    logic        op_valid;

    // In IDLE the aligner sees the incoming op; afterwards it sees the held one.
    assign align_op   = (state == ST_IDLE) ? mem_op_i : op_q;
    assign align_addr = (state == ST_IDLE) ? mem_addr_i[1:0] : addr_q[1:0];
    assign op_valid   = op_is_load(mem_op_i) || op_is_store(mem_op_i);

    mem_align u_align (
        .op         (align_op),
        .addr_lo    (align_addr),
        .wdata      (mem_wdata_i),
        .rdata      (bus_rdata_i),
        .be         (al_be),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata),
        .misaligned (al_mis)
    );

    assign bus_addr_o  = {addr_q[31:2], 2'b00};
    assign bus_wdata_o = wdata_q;
    assign bus_be_o    = (state == ST_ACCESS) ? be_q : 4'b0000;
    assign bus_we_o    = (state == ST_ACCESS) && op_is_store(op_q);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Latch the access on launch, count wait cycles, capture load data on ack.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: datapath registers are reset too, so a reset mid-access leaves no stale data visible.
        if (rst) begin
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            op_q    <= '0;
            be_q    <= '0;
            rd_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (op_valid && !al_mis) begin
                        addr_q  <= mem_addr_i;
                        op_q    <= mem_op_i;
                        wdata_q <= al_wdata;
                        be_q    <= al_be;
                        rd_q    <= write_reg_addr_i;
                    end
                end
                ST_ACCESS: begin
                    if (bus_ack_i) begin
                        if (op_is_load(op_q)) data_q <= al_rdata;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and per-state outputs; everything is quiet while rst is held.
    always_comb begin
        state_nxt        = state;
        stall_o          = 1'b0;
        bus_req_o        = 1'b0;
        mem_err_o        = 1'b0;
        write_reg_en_o   = 1'b0;
        write_reg_addr_o = '0;
        write_reg_data_o = '0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (!op_valid) begin
                        write_reg_en_o   = write_reg_en_i;
                        write_reg_addr_o = write_reg_addr_i;
                        write_reg_data_o = write_reg_data_i;
                    end else if (al_mis) begin
                        state_nxt = ST_ERR;
                    end else begin
                        stall_o   = 1'b1;
                        state_nxt = ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    bus_req_o = 1'b1;
                    stall_o   = 1'b1;
                    if (bus_ack_i)            state_nxt = ST_DONE;
                    else if (cnt == CNT_LAST) state_nxt = ST_ERR;
                end
                ST_DONE: begin
                    state_nxt = ST_IDLE;
                    if (op_is_load(op_q)) begin
                        write_reg_en_o   = 1'b1;
                        write_reg_addr_o = rd_q;
                        write_reg_data_o = data_q;
                    end
                end
                ST_ERR: begin
                    mem_err_o = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: expected writebacks go into a scoreboard
// queue when an op is driven and are matched when the DUT writes back.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int TO = 4;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic        write_reg_en_i;
    logic [4:0]  write_reg_addr_i;
    logic [31:0] write_reg_data_i;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        stall_o, write_reg_en_o, mem_err_o;
    logic [4:0]  write_reg_addr_o;
    logic [31:0] write_reg_data_o;

    int  n_checks = 0;
    int  n_pass   = 0;
    wb_t sb_q[$];
    wb_t mon_exp;
    logic [4:0] rd_next = 5'd1;

    mem_ctrl #(.TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_op_i         (mem_op_i),
        .mem_addr_i       (mem_addr_i),
        .mem_wdata_i      (mem_wdata_i),
        .write_reg_en_i   (write_reg_en_i),
        .write_reg_addr_i (write_reg_addr_i),
        .write_reg_data_i (write_reg_data_i),
        .bus_req_o        (bus_req_o),
        .bus_we_o         (bus_we_o),
        .bus_addr_o       (bus_addr_o),
        .bus_be_o         (bus_be_o),
        .bus_wdata_o      (bus_wdata_o),
        .bus_ack_i        (bus_ack_i),
        .bus_rdata_i      (bus_rdata_i),
        .stall_o          (stall_o),
        .write_reg_en_o   (write_reg_en_o),
        .write_reg_addr_o (write_reg_addr_o),
        .write_reg_data_o (write_reg_data_o),
        .mem_err_o        (mem_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Scoreboard consumer: every writeback must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && write_reg_en_o) begin
            if (sb_q.size() > 0) begin
                mon_exp = sb_q.pop_front();
                check("wb_addr", 32'(write_reg_addr_o), 32'(mon_exp.addr));
                check("wb_data", write_reg_data_o, mon_exp.data);
            end else begin
                check("wb_unexpected", 32'(write_reg_en_o), 32'd0);
            end
        end
    end

    // Present one op, emulate the bus (ack on the ack_at-th request cycle, 0 = never),
    // advance the pipeline whenever stall_o is low, and check cycle-level behaviour.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int ack_at,
                          input bit mis, input logic [3:0] exp_be, input logic [31:0] exp_bwdata,
                          input bit is_load, input logic [31:0] exp_wb);
        int req_n = 0, stall_n = 0, err_n = 0, err_cyc = -1, wb_n = 0, wb_cyc = -1;
        int exp_req, exp_stall, exp_err_cyc;
        bit normal, adv, exp_we;
        logic [4:0] rd;
        rd = rd_next;
        rd_next = rd_next + 5'd1;
        exp_we = (op >= OP_SB) && (op <= OP_SW);
        normal = !mis && (ack_at > 0);
        if (mis) begin
            exp_req = 0; exp_stall = 0; exp_err_cyc = 1;
        end else if (normal) begin
            exp_req = ack_at; exp_stall = ack_at + 1; exp_err_cyc = -1;
        end else begin
            exp_req = TO; exp_stall = TO + 1; exp_err_cyc = TO + 1;
        end
        if (normal && is_load) sb_q.push_back('{addr: rd, data: exp_wb});

        @(posedge clk); #1;
        mem_op_i = op; mem_addr_i = addr; mem_wdata_i = wdata;
        write_reg_addr_i = rd; bus_ack_i = 1'b0; bus_rdata_i = ~rdata;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus_req_o) begin
                req_n++;
                check({tag, "_be"},   32'(bus_be_o), 32'(exp_be));
                check({tag, "_we"},   32'(bus_we_o), 32'(exp_we));
                check({tag, "_addr"}, bus_addr_o, {addr[31:2], 2'b00});
                if (exp_we) check({tag, "_wdata"}, bus_wdata_o, exp_bwdata);
            end
            if (stall_o) stall_n++;
            if (mem_err_o) begin err_n++; err_cyc = c; end
            if (write_reg_en_o) begin wb_n++; wb_cyc = c; end
            adv = !stall_o;
            @(posedge clk); #1;
            if (adv) mem_op_i = OP_NOP;
            bus_ack_i   = bus_req_o && (req_n + 1 == ack_at);
            bus_rdata_i = bus_ack_i ? rdata : ~rdata;
        end
        bus_ack_i = 1'b0;
        check({tag, "_req_cycles"},   32'(req_n),   32'(exp_req));
        check({tag, "_stall_cycles"}, 32'(stall_n), 32'(exp_stall));
        check({tag, "_err_pulses"},   32'(err_n),   normal ? 32'd0 : 32'd1);
        if (!normal) check({tag, "_err_cycle"}, 32'(err_cyc), 32'(exp_err_cyc));
        check({tag, "_wb_count"}, 32'(wb_n), (normal && is_load) ? 32'd1 : 32'd0);
        if (normal && is_load) check({tag, "_wb_cycle"}, 32'(wb_cyc), 32'(ack_at + 1));
        check({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int err_n, wb_n;
        // Reset with busy-looking inputs: outputs must still be all zero.
        rst = 1'b1;
        mem_op_i = OP_LW; mem_addr_i = 32'h100; mem_wdata_i = 32'h5555AAAA;
        write_reg_en_i = 1'b1; write_reg_addr_i = 5'd9; write_reg_data_i = 32'hCAFEF00D;
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        #12;
        check("rst_req",   32'(bus_req_o), 32'd0);
        check("rst_we",    32'(bus_we_o), 32'd0);
        check("rst_be",    32'(bus_be_o), 32'd0);
        check("rst_addr",  bus_addr_o, 32'd0);
        check("rst_wdata", bus_wdata_o, 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_err",   32'(mem_err_o), 32'd0);
        check("rst_wb_en", 32'(write_reg_en_o), 32'd0);
        check("rst_wb_addr", 32'(write_reg_addr_o), 32'd0);
        check("rst_wb_data", write_reg_data_o, 32'd0);
        mem_op_i = OP_NOP; write_reg_en_i = 1'b0;
        write_reg_addr_i = 5'd0; write_reg_data_i = 32'd0;
        @(negedge clk); rst = 1'b0;

        // NOP passthrough (code 0 and an unused code), with a stray ack that must be ignored.
        @(posedge clk); #1;
        write_reg_en_i = 1'b1; write_reg_addr_i = 5'd7; write_reg_data_i = 32'h12345678;
        sb_q.push_back('{addr: 5'd7, data: 32'h12345678});
        @(negedge clk);
        check("nop_stall", 32'(stall_o), 32'd0);
        check("nop_req",   32'(bus_req_o), 32'd0);
        @(posedge clk); #1;
        mem_op_i = 4'd12; bus_ack_i = 1'b1;
        write_reg_addr_i = 5'd3; write_reg_data_i = 32'h0BADC0DE;
        sb_q.push_back('{addr: 5'd3, data: 32'h0BADC0DE});
        @(negedge clk);
        check("nop12_stall", 32'(stall_o), 32'd0);
        check("nop12_req",   32'(bus_req_o), 32'd0);
        @(posedge clk); #1;
        mem_op_i = OP_NOP; bus_ack_i = 1'b0; write_reg_en_i = 1'b0;
        @(negedge clk);
        check("nop_err", 32'(mem_err_o), 32'd0);
        check("nop_sb_drained", 32'(sb_q.size()), 32'd0);

        // Loads, stores, misaligned, timeout.
        run_op("lw_ack3",  OP_LW,  32'h100, 32'h0, 32'hDEADBEEF, 3, 0, 4'b1111, 32'h0, 1, 32'hDEADBEEF);
        run_op("lb_sext",  OP_LB,  32'h203, 32'h0, 32'h80112233, 1, 0, 4'b1000, 32'h0, 1, 32'hFFFFFF80);
        run_op("lbu_zext", OP_LBU, 32'h203, 32'h0, 32'h80112233, 1, 0, 4'b1000, 32'h0, 1, 32'h00000080);
        run_op("lh_hi",    OP_LH,  32'h202, 32'h0, 32'h80112233, 2, 0, 4'b1100, 32'h0, 1, 32'hFFFF8011);
        run_op("lhu_lo",   OP_LHU, 32'h200, 32'h0, 32'h80119233, 1, 0, 4'b0011, 32'h0, 1, 32'h00009233);
        run_op("lb_lane1", OP_LB,  32'h501, 32'h0, 32'h80117F33, 1, 0, 4'b0010, 32'h0, 1, 32'h0000007F);
        run_op("sh_hi",    OP_SH,  32'h302, 32'h0000ABCD, 32'h0, 2, 0, 4'b1100, 32'hABCDABCD, 0, 32'h0);
        run_op("sb_lane1", OP_SB,  32'h101, 32'h1234565A, 32'h0, 1, 0, 4'b0010, 32'h5A5A5A5A, 0, 32'h0);
        run_op("sw",       OP_SW,  32'h040, 32'h11223344, 32'h0, 1, 0, 4'b1111, 32'h11223344, 0, 32'h0);
        run_op("lw_mis",   OP_LW,  32'h101, 32'h0, 32'h0, 1, 1, 4'b0000, 32'h0, 1, 32'h0);
        run_op("lh_mis",   OP_LH,  32'h201, 32'h0, 32'h0, 1, 1, 4'b0000, 32'h0, 1, 32'h0);
        run_op("lw_tmo",   OP_LW,  32'h600, 32'h0, 32'h0, 0, 0, 4'b1111, 32'h0, 1, 32'h0);
        run_op("lw_ack4",  OP_LW,  32'h604, 32'h0, 32'h76543210, TO, 0, 4'b1111, 32'h0, 1, 32'h76543210);

        // Reset during the second ACCESS cycle abandons the load silently.
        @(posedge clk); #1;
        mem_op_i = OP_LW; mem_addr_i = 32'h400; write_reg_addr_i = 5'd20;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_rst_pre_req", 32'(bus_req_o), 32'd1);
        rst = 1'b1; #1;
        check("mid_rst_req",   32'(bus_req_o), 32'd0);
        check("mid_rst_stall", 32'(stall_o), 32'd0);
        check("mid_rst_be",    32'(bus_be_o), 32'd0);
        check("mid_rst_addr",  bus_addr_o, 32'd0);
        mem_op_i = OP_NOP;
        @(posedge clk); #1;
        rst = 1'b0;
        err_n = 0; wb_n = 0;
        for (int c = 0; c < 6; c++) begin
            bus_ack_i = 1'b1;
            @(negedge clk);
            if (mem_err_o) err_n++;
            if (write_reg_en_o) wb_n++;
        end
        bus_ack_i = 1'b0;
        check("mid_rst_no_err", 32'(err_n), 32'd0);
        check("mid_rst_no_wb",  32'(wb_n), 32'd0);
        check("final_sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
